hk_boot_loader: RTL and testbench
=================================

HK_BOOT_LOADER -- requirements
Module: hk_boot_loader

Interface
REQ-001 Parameter BOOT_WORDS, default 32: number of 32-bit image words copied; legal range 1..65535.
REQ-002 Parameter FLASH_BASE_ADDR, default 32'h0000_0000: flash byte address of image word 0.
REQ-003 Parameter SRAM_BASE_ADDR, default 32'h0000_0000: SRAM byte address of image word 0.
REQ-004 Parameter ADDR_BYTES, default 3: flash address length; 3 selects READ 0x03, 4 selects READ4 0x13; other values are an elaboration error.
REQ-005 Parameter SCK_DIV, default 2: SCK half-period in clk_i cycles; minimum 1.
REQ-006 Ports: clk_i in 1 clock; reset_i in 1 reset, one clock, synchronous, active-high.
REQ-007 Ports: spi_sck_o out 1; spi_mosi_o out 1; spi_miso_i in 1; flash_csb_o out 1, active-low chip select.
REQ-008 Ports: arb_req_o out 1, SRAM bus request; arb_gnt_i in 1, grant.
REQ-009 Ports: sram_wr_en_o out 1; sram_addr_o out 32; sram_data_o out 32.
REQ-010 Ports: cores_en_o out 1; boot_done_o out 1; boot_err_o out 1.

Function
REQ-011 SPI SHALL be mode 0, MSB first: MOSI changes on SCK falling edge or at byte start, MISO sampled on SCK rising edge; one byte SHALL take 16*SCK_DIV cycles.
REQ-012 States: IDLE -> CMD -> ADDR -> READ -> ARB -> WRITE -> (READ | CHECK | DONE); ERR is terminal.
REQ-013 IDLE SHALL last exactly one cycle after reset release, then drive flash_csb_o low and enter CMD.
REQ-014 CMD SHALL send the single opcode byte; ADDR SHALL send FLASH_BASE_ADDR low ADDR_BYTES bytes, MSB first.
REQ-015 READ SHALL shift in 4 bytes, assembled little-endian (first byte -> bits [7:0]); MOSI SHALL be 0 during reads.
REQ-016 ARB SHALL hold arb_req_o=1 with SCK idle low and flash_csb_o low until arb_gnt_i=1 is sampled.
REQ-017 WRITE SHALL last one cycle: sram_wr_en_o=1, arb_req_o=1, sram_addr_o=SRAM_BASE_ADDR+4*index (32-bit wrap), sram_data_o=assembled word; arb_req_o SHALL drop the next cycle.
REQ-018 After WRITE of index BOOT_WORDS-1, next state SHALL be CHECK with HK_BOOT_CRC_EN, else DONE; otherwise READ with index+1.
REQ-019 On DONE entry flash_csb_o SHALL go high; the next cycle cores_en_o=1 and boot_done_o=1, held until reset.
REQ-020 sram_wr_en_o SHALL never assert without arb_gnt_i sampled high in the previous cycle; arb_gnt_i outside ARB SHALL be ignored.
REQ-021 Back-to-back word streaming: flash_csb_o SHALL stay low from CMD through the last READ (single continuous read burst).

Reset
REQ-022 reset_i=1 at any clock edge SHALL force IDLE, index=0, flash_csb_o=1, spi_sck_o=0, spi_mosi_o=0, arb_req_o=0, sram_wr_en_o=0, sram_addr_o=0, sram_data_o=0, cores_en_o=0, boot_done_o=0, boot_err_o=0, CRC state reinitialised.
REQ-023 Reset mid-transfer SHALL abort without a partial SRAM write and restart the whole copy from word 0 after release.

Configuration
REQ-024 Macro HK_BOOT_CRC_EN defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) SHALL accumulate over every image byte in flash order.
REQ-025 With HK_BOOT_CRC_EN, CHECK SHALL read one further little-endian word (not written to SRAM); match -> DONE, mismatch -> ERR: flash_csb_o=1, boot_done_o=1, boot_err_o=1, cores_en_o=0 held until reset.
REQ-026 HK_BOOT_CRC_EN undefined: no CRC logic, no CHECK state, boot_err_o tied 0.

Structure
REQ-027 Package hk_boot_pkg SHALL hold the state enum, opcodes 0x03/0x13, CRC polynomial and init/xor constants.
REQ-028 Sub-module hk_spi_byte (start/done byte shifter parametrised by SCK_DIV) SHALL implement REQ-011; hk_boot_loader holds FSM, counters, CRC.

Verification
REQ-029 BOOT_WORDS=4, ADDR_BYTES=3, FLASH_BASE_ADDR=0x001000, gnt tied 1 -> MOSI 03 00 10 00; 4 writes at 0x0,0x4,0x8,0xC; flash bytes 78 56 34 12 -> data 0x12345678; boot_done_o and cores_en_o rise.
REQ-030 ADDR_BYTES=4, FLASH_BASE_ADDR=0x01020304 -> MOSI 13 01 02 03 04, 40 SCK rising edges before the first data bit.
REQ-031 gnt held 0 for 50 cycles on word 2 -> arb_req_o high throughout, SCK static, csb low, no write until gnt; data intact.
REQ-032 reset_i pulsed during word 3 READ -> csb high next cycle, no write for word 3, copy restarts with opcode and word 0.
REQ-033 HK_BOOT_CRC_EN, correct trailer -> cores_en_o=1, boot_err_o=0; one flipped image bit -> boot_err_o=1, boot_done_o=1, cores_en_o=0.
REQ-034 SRAM_BASE_ADDR=0xFFFF_FFF8, BOOT_WORDS=3 -> write addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/hk_boot_pkg.sv
// Shared state encoding and flash/CRC constants for the SPI boot loader.
// HK_BOOT_CRC_EN adds the CHECK state and the CRC-32 helpers.
package hk_boot_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_READ,
    S_ARB,
    S_WRITE,
`ifdef HK_BOOT_CRC_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] OPC_READ3 = 8'h03;
  localparam logic [7:0] OPC_READ4 = 8'h13;

`ifdef HK_BOOT_CRC_EN
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_POLY_REFL = {<<{CRC_POLY}};
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOR       = 32'hFFFF_FFFF;

  // Reflected CRC: the byte enters LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/hk_boot_loader_spi_byte.sv
// hk_spi_byte: one mode-0 SPI byte transfer, MSB first, 16*SCK_DIV cycles per byte.
// SCK phases are timed by a down-counter reloaded at terminal count.
module hk_spi_byte #(
  parameter int SCK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int DW = (SCK_DIV < 2) ? 1 : $clog2(SCK_DIV);
  localparam logic [DW-1:0] DIV_LOAD = DW'(SCK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [3:0]    phase;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt <= '0;
      phase   <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          phase   <= '0;
          div_cnt <= DIV_LOAD;
          sck     <= 1'b0;
          mosi    <= tx_byte[7];
          tx_sr   <= {tx_byte[6:0], 1'b0};
        end
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        div_cnt <= DIV_LOAD;
        // Phase 15 is the eighth SCK-high half; its end closes the byte.
        if (phase == 4'd15) begin
          busy <= 1'b0;
          done <= 1'b1;
          sck  <= 1'b0;
          mosi <= 1'b0;
        end else begin
          phase <= phase + 4'd1;
          sck   <= ~sck;
          if (!sck) begin
            rx_sr <= {rx_sr[6:0], miso};
          end else begin
            mosi  <= tx_sr[7];
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign rx_byte = rx_sr;

endmodule

// File: rtl/hk_boot_loader.sv
// hk_boot_loader: streams BOOT_WORDS words out of SPI flash in one read burst into SRAM.
// Define HK_BOOT_CRC_EN to verify a trailing CRC-32 word before releasing the cores.
//
// state   | meaning
// IDLE    | one cycle after reset, chip select still high
// CMD     | send read opcode (0x03 or 0x13)
// ADDR    | send flash base address, MSB first
// READ    | shift in 4 image bytes, little-endian
// ARB     | request SRAM bus, SCK parked low, wait for grant
// WRITE   | single-cycle SRAM write of the assembled word
// CHECK   | read CRC trailer word (HK_BOOT_CRC_EN only)
// DONE    | chip select high, cores released
// ERR     | CRC mismatch, cores held off until reset
module hk_boot_loader
  import hk_boot_pkg::*;
#(
  parameter int unsigned BOOT_WORDS      = 32,
  parameter logic [31:0] FLASH_BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] SRAM_BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_BYTES      = 3,
  parameter int          SCK_DIV         = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        flash_csb_o,
  output logic        arb_req_o,
  input  logic        arb_gnt_i,
  output logic        sram_wr_en_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_data_o,
  output logic        cores_en_o,
  output logic        boot_done_o,
  output logic        boot_err_o
);

  if (ADDR_BYTES != 3 && ADDR_BYTES != 4) begin : g_bad_addr_bytes
    $error("hk_boot_loader: ADDR_BYTES must be 3 or 4");
  end
  if (SCK_DIV < 1 || BOOT_WORDS < 1 || BOOT_WORDS > 65535) begin : g_bad_params
    $error("hk_boot_loader: SCK_DIV or BOOT_WORDS out of range");
  end

  localparam logic [7:0]  OPCODE    = (ADDR_BYTES == 4) ? OPC_READ4 : OPC_READ3;
  localparam logic [1:0]  ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [15:0] WORD_LAST = 16'(BOOT_WORDS - 1);

  state_t      state_q, state_d;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [31:0] word_q;
  logic [31:0] addr_q;
  logic        cores_en_q, boot_done_q;
  logic        rx_state;

  logic        spi_start, spi_busy, spi_done, spi_idle;
  logic [7:0]  tx_byte, spi_rx;
  logic [1:0]  addr_sel;
  logic [31:0] addr_shift;

  assign spi_idle   = !spi_busy && !spi_done;
  assign addr_sel   = ADDR_LAST - byte_idx;
  assign addr_shift = FLASH_BASE_ADDR >> {addr_sel, 3'b000};

`ifdef HK_BOOT_CRC_EN
  logic [31:0] crc_q;
  logic        crc_ok;
  logic        boot_err_q;
  assign crc_ok = ({spi_rx, word_q[31:8]} == (crc_q ^ CRC_XOR));
`endif

  hk_spi_byte #(.SCK_DIV(SCK_DIV)) u_spi (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start   (spi_start),
    .tx_byte (tx_byte),
    .miso    (spi_miso_i),
    .sck     (spi_sck_o),
    .mosi    (spi_mosi_o),
    .busy    (spi_busy),
    .done    (spi_done),
    .rx_byte (spi_rx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    spi_start = 1'b0;
    tx_byte   = 8'h00;
    rx_state  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_CMD;
      S_CMD: begin
        tx_byte   = OPCODE;
        spi_start = spi_idle;
        if (spi_done) state_d = S_ADDR;
      end
      S_ADDR: begin
        tx_byte   = addr_shift[7:0];
        spi_start = spi_idle;
        if (spi_done && byte_idx == ADDR_LAST) state_d = S_READ;
      end
      S_READ: begin
        rx_state  = 1'b1;
        spi_start = spi_idle;
        if (spi_done && byte_idx == 2'd3) state_d = S_ARB;
      end
      S_ARB: if (arb_gnt_i) state_d = S_WRITE;
      S_WRITE: begin
        if (word_idx == WORD_LAST) begin
`ifdef HK_BOOT_CRC_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_READ;
        end
      end
`ifdef HK_BOOT_CRC_EN
      S_CHECK: begin
        rx_state  = 1'b1;
        spi_start = spi_idle;
        if (spi_done && byte_idx == 2'd3) state_d = crc_ok ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_idx    <= '0;
      word_idx    <= '0;
      word_q      <= '0;
      addr_q      <= SRAM_BASE_ADDR;
      cores_en_q  <= 1'b0;
      boot_done_q <= 1'b0;
    end else begin
      if (state_d != state_q) byte_idx <= '0;
      else if (spi_done)      byte_idx <= byte_idx + 2'd1;
      // First flash byte ends up in bits [7:0].
      if (spi_done && rx_state) word_q <= {spi_rx, word_q[31:8]};
      if (state_q == S_WRITE) begin
        word_idx <= word_idx + 16'd1;
        addr_q   <= addr_q + 32'd4;
      end
      cores_en_q  <= (state_q == S_DONE);
      boot_done_q <= (state_q == S_DONE) || (state_q == S_ERR);
    end
  end

`ifdef HK_BOOT_CRC_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      crc_q      <= CRC_INIT;
      boot_err_q <= 1'b0;
    end else begin
      if (spi_done && state_q == S_READ) crc_q <= crc32_byte(crc_q, spi_rx);
      boot_err_q <= (state_q == S_ERR);
    end
  end
  assign boot_err_o = boot_err_q;
`else
  assign boot_err_o = 1'b0;
`endif

  assign flash_csb_o  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign arb_req_o    = (state_q == S_ARB) || (state_q == S_WRITE);
  assign sram_wr_en_o = (state_q == S_WRITE);
  assign sram_addr_o  = sram_wr_en_o ? addr_q : 32'd0;
  assign sram_data_o  = sram_wr_en_o ? word_q : 32'd0;
  assign cores_en_o   = cores_en_q;
  assign boot_done_o  = boot_done_q;

endmodule

// File: tb/tb_hk_boot_loader.sv
// Bench for hk_boot_loader: behavioural SPI flash, SRAM write log and directed boot scenarios.
// Works with or without HK_BOOT_CRC_EN.
module tb_hk_boot_loader;

  localparam int          BW     = 4;
  localparam int          AB     = 4;
  localparam logic [31:0] FBASE  = 32'h0102_0304;
  localparam logic [31:0] SBASE  = 32'hFFFF_FFF8;
  localparam int          HDR    = 8 * (1 + AB);
  localparam int          NBYTES = 4 * BW + 4;

  logic clk = 1'b0, reset = 1'b1, miso = 1'b0, gnt = 1'b0;
  logic sck, mosi, csb, arb_req, wr_en, cores_en, boot_done, boot_err;
  logic [31:0] sram_addr, sram_data;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  hk_boot_loader #(
    .BOOT_WORDS(BW), .FLASH_BASE_ADDR(FBASE), .SRAM_BASE_ADDR(SBASE),
    .ADDR_BYTES(AB), .SCK_DIV(2)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .spi_sck_o(sck), .spi_mosi_o(mosi), .spi_miso_i(miso), .flash_csb_o(csb),
    .arb_req_o(arb_req), .arb_gnt_i(gnt),
    .sram_wr_en_o(wr_en), .sram_addr_o(sram_addr), .sram_data_o(sram_data),
    .cores_en_o(cores_en), .boot_done_o(boot_done), .boot_err_o(boot_err)
  );

  // Flash image: BW words followed by a CRC trailer word.
  logic [7:0] img [NBYTES];
  logic [7:0] mosi_bytes [8];
  int   rise_cnt = 0, mosi_nz = 0;
  logic [7:0] mosi_acc = 8'h00;
  logic sck_prev = 1'b0, csb_prev = 1'b1;

  function automatic logic flash_bit(input int b);
    int d;
    if (b < HDR) return 1'b0;
    d = b - HDR;
    if (d / 8 >= NBYTES) return 1'b0;
    return img[d / 8][7 - (d % 8)];
  endfunction

  always @(sck or csb) begin
    if (csb === 1'b0 && csb_prev === 1'b1) begin
      rise_cnt = 0;
      for (int i = 0; i < 8; i++) mosi_bytes[i] = 8'h00;
      miso = 1'b0;
    end
    if (csb === 1'b0 && sck === 1'b1 && sck_prev === 1'b0) begin
      mosi_acc = {mosi_acc[6:0], mosi};
      if (rise_cnt >= HDR && mosi !== 1'b0) mosi_nz++;
      rise_cnt++;
      if (rise_cnt % 8 == 0 && rise_cnt <= HDR) mosi_bytes[rise_cnt / 8 - 1] = mosi_acc;
    end else if (csb === 1'b0 && sck === 1'b0 && sck_prev === 1'b1) begin
      miso = flash_bit(rise_cnt);
    end
    if (csb === 1'b1) miso = 1'b0;
    sck_prev = sck;
    csb_prev = csb;
  end

  // SRAM write log plus grant-before-write tracking.
  logic [31:0] wr_addr_log [32];
  logic [31:0] wr_data_log [32];
  int   wr_n = 0, gnt_viol = 0, stall_bad = 0;
  logic gnt_at_edge = 1'b0;

  always @(posedge clk) gnt_at_edge <= gnt;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (gnt_at_edge !== 1'b1) gnt_viol++;
      if (wr_n < 32) begin
        wr_addr_log[wr_n] = sram_addr;
        wr_data_log[wr_n] = sram_data;
      end
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_image();
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 4 * BW; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ img[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic new_image();
    logic [31:0] crc;
    for (int i = 0; i < 4 * BW; i++) img[i] = 8'($urandom);
    crc = crc_image();
    for (int k = 0; k < 4; k++) img[4 * BW + k] = crc[8 * k +: 8];
  endtask

  int cyc_csb_hi, cyc_done;

  task automatic run_boot(input bit rnd_gnt, input bit do_stall, output bit ok);
    bit csb_p, stalled;
    int base;
    csb_p = 1'b0; stalled = 1'b0; base = wr_n;
    ok = 1'b0; cyc_csb_hi = -100; cyc_done = -1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (do_stall && !stalled && arb_req === 1'b1 && wr_en === 1'b0 && wr_n - base == 2) begin
        stalled = 1'b1;
        gnt = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (arb_req !== 1'b1 || csb !== 1'b0 || sck !== 1'b0 || wr_en !== 1'b0) stall_bad++;
        end
        gnt = 1'b1;
        continue;
      end
      if (csb === 1'b1 && csb_p == 1'b0) cyc_csb_hi = c;
      if (boot_done === 1'b1) begin
        cyc_done = c;
        ok = 1'b1;
        break;
      end
      csb_p = csb;
      gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic check_words(input string tag, input int base);
    logic [31:0] ea, ed;
    for (int i = 0; i < BW; i++) begin
      ea = SBASE + 32'(4 * i);
      ed = {img[4 * i + 3], img[4 * i + 2], img[4 * i + 1], img[4 * i]};
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_log[base + i], ea);
      chk($sformatf("%s_data%0d", tag, i), wr_data_log[base + i], ed);
    end
  endtask

  task automatic check_header(input string tag);
    logic [7:0] eb;
    chk({tag, "_opcode"}, 32'(mosi_bytes[0]), (AB == 4) ? 32'h13 : 32'h03);
    for (int k = 1; k <= AB; k++) begin
      eb = 8'(FBASE >> (8 * (AB - k)));
      chk($sformatf("%s_addr_byte%0d", tag, k), 32'(mosi_bytes[k]), 32'(eb));
    end
  endtask

  initial begin
    bit ok;
    int base;
    new_image();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_csb", csb, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_arb_req", arb_req, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_data", sram_data, 0);
    chk("rst_cores_en", cores_en, 0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_boot_err", boot_err, 0);

    // Boot 1: random grant, 50-cycle grant stall on word 2.
    reset = 1'b0;
    @(negedge clk);
    chk("csb_low_after_idle", csb, 0);
    base = wr_n;
    run_boot(1'b1, 1'b1, ok);
    chk("boot1_finished", 32'(ok), 1);
    chk("boot1_write_count", 32'(wr_n - base), BW);
    check_words("boot1", base);
    check_header("boot1");
    chk("boot1_mosi_zero_in_read", 32'(mosi_nz), 0);
    chk("stall_held", 32'(stall_bad), 0);
    chk("done_after_csb_high", 32'(cyc_done - cyc_csb_hi), 1);
    chk("boot1_cores_en", cores_en, 1);
    chk("boot1_err", boot_err, 0);
    chk("boot1_csb_high", csb, 1);
    chk("boot1_arb_req_low", arb_req, 0);
    gnt = 1'b1;
    repeat (20) @(negedge clk);
    chk("cores_en_held", cores_en, 1);
    chk("no_extra_writes", 32'(wr_n - base), BW);

    // Boot 2: reset pulse while reading word 3, then full restart.
    new_image();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mosi_nz = 0;
    base = wr_n;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (wr_n - base >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reached_word3", 32'(ok), 1);
    repeat (20) @(negedge clk);
    chk("word3_in_read_csb", csb, 0);
    chk("word3_in_read_no_req", arb_req, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_csb_high", csb, 1);
    chk("abort_sck_low", sck, 0);
    chk("abort_no_write", wr_en, 0);
    reset = 1'b0;
    chk("abort_write_count", 32'(wr_n - base), 3);
    base = wr_n;
    run_boot(1'b0, 1'b0, ok);
    chk("boot2_finished", 32'(ok), 1);
    chk("boot2_write_count", 32'(wr_n - base), BW);
    check_words("boot2", base);
    check_header("boot2");
    chk("boot2_mosi_zero_in_read", 32'(mosi_nz), 0);
    chk("boot2_cores_en", cores_en, 1);
    chk("grant_before_write", 32'(gnt_viol), 0);

`ifdef HK_BOOT_CRC_EN
    // Boot 3: one image bit flipped after the trailer was computed.
    img[5] = img[5] ^ 8'h10;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_boot(1'b1, 1'b0, ok);
    chk("boot3_finished", 32'(ok), 1);
    repeat (3) @(negedge clk);
    chk("boot3_err", boot_err, 1);
    chk("boot3_done", boot_done, 1);
    chk("boot3_cores_off", cores_en, 0);
    chk("boot3_csb_high", csb, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
